// File: rtl/accelerator_convolution_arbiter.sv
// accelerator_convolution_arbiter: round-robin arbiter that lets four gate
//   controllers share one matrix convolution engine, one transaction at a time.
// Latency: request to DONE_OUT is 4 CLK edges minimum (grant, start, wait, done);
//   a new grant is possible every 4 cycles.
// Backpressure: REQ_IN is level-held and re-evaluated only in IDLE; WAIT holds
//   until ENGINE_READY arrives, or until the watchdog expires when it is enabled.
// Optional feature macro: ACCELERATOR_CONVOLUTION_ARBITER_WATCHDOG_EN enables the
//   WAIT-state watchdog (ERROR_OUT pulse after TIMEOUT_CYCLES WAIT cycles).
// Ports:
//   CLK, RST           clock, asynchronous active-high reset (also resets the engine)
//   REQ_IN             per-requester request level
//   DATA_A_IN/B_IN     packed operands, requester n at [n*DATA_SIZE +: DATA_SIZE]
//   GNT_OUT            one-hot grant or zero
//   DONE_OUT           one-cycle completion pulse to the granted requester
//   RESULT_OUT         last captured engine result
//   BUSY_OUT           high whenever the FSM is not in IDLE
//   ERROR_OUT          one-cycle watchdog abort pulse
//   ENGINE_*           start strobe, ready strobe, latched operands, result
module accelerator_convolution_arbiter #(
  parameter int DATA_SIZE      = 64,
  parameter int REQUESTERS     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [REQUESTERS-1:0]           REQ_IN,
  input  logic [REQUESTERS*DATA_SIZE-1:0] DATA_A_IN,
  input  logic [REQUESTERS*DATA_SIZE-1:0] DATA_B_IN,
  output logic [REQUESTERS-1:0]           GNT_OUT,
  output logic [REQUESTERS-1:0]           DONE_OUT,
  output logic [DATA_SIZE-1:0]            RESULT_OUT,
  output logic                            BUSY_OUT,
  output logic                            ERROR_OUT,
  output logic                            ENGINE_START,
  input  logic                            ENGINE_READY,
  output logic [DATA_SIZE-1:0]            ENGINE_DATA_A,
  output logic [DATA_SIZE-1:0]            ENGINE_DATA_B,
  input  logic [DATA_SIZE-1:0]            ENGINE_DATA_OUT
);

  localparam int IDX_W = $clog2(REQUESTERS);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_DONE} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [REQUESTERS-1:0]   gnt_q, gnt_d;
  logic [REQUESTERS-1:0]   done_q, done_d;
  logic                    err_q, err_d;
  logic [DATA_SIZE-1:0]    result_q, result_d;
  logic [DATA_SIZE-1:0]    eng_a_q, eng_a_d;
  logic [DATA_SIZE-1:0]    eng_b_q, eng_b_d;

`ifdef ACCELERATOR_CONVOLUTION_ARBITER_WATCHDOG_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Counts completed WAIT cycles; the abort fires in the TIMEOUT_CYCLES-th one.
  logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

  // Round-robin pick: first asserted request at or after ptr_q, wrapping.
  logic                    pick_vld;
  logic [IDX_W-1:0]        pick_idx;
  logic [IDX_W-1:0]        cand;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr_q;
    cand     = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      cand = ptr_q + IDX_W'(k);
      if (!pick_vld && REQ_IN[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    err_d    = 1'b0;
    result_d = result_q;
    eng_a_d  = eng_a_q;
    eng_b_d  = eng_b_q;
`ifdef ACCELERATOR_CONVOLUTION_ARBITER_WATCHDOG_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d         = ST_START;
          idx_d           = pick_idx;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          eng_a_d         = DATA_A_IN[int'(pick_idx)*DATA_SIZE +: DATA_SIZE];
          eng_b_d         = DATA_B_IN[int'(pick_idx)*DATA_SIZE +: DATA_SIZE];
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
`ifdef ACCELERATOR_CONVOLUTION_ARBITER_WATCHDOG_EN
        cnt_d   = '0;
`endif
      end
      ST_WAIT: begin
        // A ready strobe in the expiry cycle still wins over the abort.
        if (ENGINE_READY) begin
          result_d = ENGINE_DATA_OUT;
          state_d  = ST_DONE;
        end
`ifdef ACCELERATOR_CONVOLUTION_ARBITER_WATCHDOG_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Abort straight to IDLE: requester still gets its DONE pulse,
          // RESULT_OUT keeps the previous result.
          err_d   = 1'b1;
          done_d  = gnt_q;
          gnt_d   = '0;
          ptr_d   = idx_q + IDX_W'(1);
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_DONE: begin
        done_d  = gnt_q;
        gnt_d   = '0;
        ptr_d   = idx_q + IDX_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      eng_a_q  <= '0;
      eng_b_q  <= '0;
`ifdef ACCELERATOR_CONVOLUTION_ARBITER_WATCHDOG_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
      eng_a_q  <= eng_a_d;
      eng_b_q  <= eng_b_d;
`ifdef ACCELERATOR_CONVOLUTION_ARBITER_WATCHDOG_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign GNT_OUT       = gnt_q;
  assign DONE_OUT      = done_q;
  assign RESULT_OUT    = result_q;
  assign BUSY_OUT      = (state_q != ST_IDLE);
  assign ENGINE_START  = (state_q == ST_START);
  assign ENGINE_DATA_A = eng_a_q;
  assign ENGINE_DATA_B = eng_b_q;

`ifdef ACCELERATOR_CONVOLUTION_ARBITER_WATCHDOG_EN
  assign ERROR_OUT = err_q;
`else
  assign ERROR_OUT = 1'b0;
  // err_q is never set without the watchdog; these keep the unused pieces referenced.
  logic unused_watchdog;
  assign unused_watchdog = err_q ^ (^TIMEOUT_CYCLES);
`endif

endmodule

// File: tb/tb_accelerator_convolution_arbiter.sv
// tb_accelerator_convolution_arbiter: directed checks of the convolution arbiter
//   with the bench acting as the engine; expected values are hand-computed.
// Stimulus is driven and outputs sampled 1 time unit after each rising CLK edge.
module tb_accelerator_convolution_arbiter;

  localparam int DW = 64;

  logic            CLK = 1'b0;
  logic            RST;
  logic [3:0]      REQ_IN;
  logic [4*DW-1:0] DATA_A_IN;
  logic [4*DW-1:0] DATA_B_IN;
  logic [3:0]      GNT_OUT;
  logic [3:0]      DONE_OUT;
  logic [DW-1:0]   RESULT_OUT;
  logic            BUSY_OUT;
  logic            ERROR_OUT;
  logic            ENGINE_START;
  logic            ENGINE_READY;
  logic [DW-1:0]   ENGINE_DATA_A;
  logic [DW-1:0]   ENGINE_DATA_B;
  logic [DW-1:0]   ENGINE_DATA_OUT;

  int n_chk  = 0;
  int n_pass = 0;

  accelerator_convolution_arbiter #(
    .DATA_SIZE(DW), .REQUESTERS(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ_IN(REQ_IN),
    .DATA_A_IN(DATA_A_IN), .DATA_B_IN(DATA_B_IN),
    .GNT_OUT(GNT_OUT), .DONE_OUT(DONE_OUT), .RESULT_OUT(RESULT_OUT),
    .BUSY_OUT(BUSY_OUT), .ERROR_OUT(ERROR_OUT),
    .ENGINE_START(ENGINE_START), .ENGINE_READY(ENGINE_READY),
    .ENGINE_DATA_A(ENGINE_DATA_A), .ENGINE_DATA_B(ENGINE_DATA_B),
    .ENGINE_DATA_OUT(ENGINE_DATA_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full transaction from an IDLE cycle whose REQ_IN selects requester g.
  task automatic txn(input int g, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] r, input bit drop_req);
    logic [3:0] oh;
    oh = 4'b0001 << g;
    tick();                                  // edge 1: START
    check_eq("gnt", GNT_OUT, oh);
    check_eq("start", ENGINE_START, 1);
    check_eq("eng_a", ENGINE_DATA_A, a);
    check_eq("eng_b", ENGINE_DATA_B, b);
    check_eq("done_one_cycle", DONE_OUT, 0);
    if (drop_req) REQ_IN[g] = 1'b0;
    tick();                                  // edge 2: WAIT
    check_eq("start_one_cycle", ENGINE_START, 0);
    check_eq("busy_wait", BUSY_OUT, 1);
    ENGINE_READY    = 1'b1;
    ENGINE_DATA_OUT = r;
    tick();                                  // edge 3: DONE
    ENGINE_READY    = 1'b0;
    ENGINE_DATA_OUT = 64'hDEAD_BEEF;
    check_eq("done_not_yet", DONE_OUT, 0);
    check_eq("result_capt", RESULT_OUT, r);
    tick();                                  // edge 4: back in IDLE
    check_eq("done_pulse", DONE_OUT, oh);
    check_eq("result_done", RESULT_OUT, r);
    check_eq("gnt_clear", GNT_OUT, 0);
    check_eq("busy_idle", BUSY_OUT, 0);
  endtask

  initial begin
    RST             = 1'b1;
    REQ_IN          = 4'b0000;
    ENGINE_READY    = 1'b0;
    ENGINE_DATA_OUT = '0;
    // Requester operands: (3,5) (4,6) (7,2) (9,11); products 15 24 14 99.
    DATA_A_IN = {64'd9,  64'd7, 64'd4, 64'd3};
    DATA_B_IN = {64'd11, 64'd2, 64'd6, 64'd5};
    tick();
    tick();
    check_eq("rst_gnt", GNT_OUT, 0);
    check_eq("rst_done", DONE_OUT, 0);
    check_eq("rst_result", RESULT_OUT, 0);
    check_eq("rst_busy", BUSY_OUT, 0);
    check_eq("rst_err", ERROR_OUT, 0);
    check_eq("rst_start", ENGINE_START, 0);
    check_eq("rst_eng_a", ENGINE_DATA_A, 0);
    RST = 1'b0;
    tick();

    // Single request from requester 0: 3*5 = 15.
    REQ_IN = 4'b0001;
    txn(0, 64'd3, 64'd5, 64'd15, 1'b0);
    REQ_IN = 4'b0000;
    tick();
    check_eq("single_done_off", DONE_OUT, 0);
    check_eq("single_idle", BUSY_OUT, 0);

    // ENGINE_READY in IDLE is ignored.
    ENGINE_READY    = 1'b1;
    ENGINE_DATA_OUT = 64'd77;
    tick();
    ENGINE_READY    = 1'b0;
    check_eq("idle_rdy_busy", BUSY_OUT, 0);
    check_eq("idle_rdy_result", RESULT_OUT, 15);
    check_eq("idle_rdy_done", DONE_OUT, 0);

    // Reset in WAIT: PTR is 1, so REQ_IN=1000 grants requester 3.
    REQ_IN = 4'b1000;
    tick();
    check_eq("pre_rst_gnt", GNT_OUT, 4'b1000);
    tick();
    REQ_IN = 4'b0000;
    RST = 1'b1;
    #1;
    check_eq("mid_rst_gnt", GNT_OUT, 0);
    check_eq("mid_rst_busy", BUSY_OUT, 0);
    check_eq("mid_rst_result", RESULT_OUT, 0);
    check_eq("mid_rst_eng_a", ENGINE_DATA_A, 0);
    tick();
    RST = 1'b0;
    tick();
    check_eq("post_rst_done", DONE_OUT, 0);
    tick();
    check_eq("post_rst_done2", DONE_OUT, 0);

    // All requesting: after reset PTR=0, order 0,1,2,3,0.
    REQ_IN = 4'b1111;
    txn(0, 64'd3, 64'd5,  64'd15, 1'b0);
    txn(1, 64'd4, 64'd6,  64'd24, 1'b0);
    txn(2, 64'd7, 64'd2,  64'd14, 1'b0);
    txn(3, 64'd9, 64'd11, 64'd99, 1'b0);
    txn(0, 64'd3, 64'd5,  64'd15, 1'b0);

    // PTR=1: serve requester 1 alone, then 0011 must wrap to requester 0.
    // Requester 0 drops its request right after the grant and still completes.
    REQ_IN = 4'b0010;
    txn(1, 64'd4, 64'd6, 64'd24, 1'b0);
    REQ_IN = 4'b0011;
    txn(0, 64'd3, 64'd5, 64'd15, 1'b1);
    REQ_IN = 4'b0000;
    tick();
    check_eq("wrap_idle", BUSY_OUT, 0);

    // Engine never answers; PTR=1 so 0100 grants requester 2.
    REQ_IN = 4'b0100;
    tick();                                  // START
    check_eq("wd_gnt", GNT_OUT, 4'b0100);
    REQ_IN = 4'b0000;
    tick();                                  // WAIT entry
`ifdef ACCELERATOR_CONVOLUTION_ARBITER_WATCHDOG_EN
    repeat (7) tick();                       // 7 edges after WAIT entry
    check_eq("wd_err_early", ERROR_OUT, 0);
    check_eq("wd_done_early", DONE_OUT, 0);
    check_eq("wd_busy_early", BUSY_OUT, 1);
    tick();                                  // 8 edges after WAIT entry
    check_eq("wd_err", ERROR_OUT, 1);
    check_eq("wd_done", DONE_OUT, 4'b0100);
    check_eq("wd_result", RESULT_OUT, 15);
    check_eq("wd_gnt_clear", GNT_OUT, 0);
    tick();
    check_eq("wd_err_off", ERROR_OUT, 0);
    check_eq("wd_idle", BUSY_OUT, 0);
    // PTR advanced to 3: 0101 wraps to requester 0.
    REQ_IN = 4'b0101;
    txn(0, 64'd3, 64'd5, 64'd15, 1'b0);
    REQ_IN = 4'b0000;
`else
    repeat (20) tick();
    check_eq("nowd_busy", BUSY_OUT, 1);
    check_eq("nowd_err", ERROR_OUT, 0);
    check_eq("nowd_done", DONE_OUT, 0);
    check_eq("nowd_gnt", GNT_OUT, 4'b0100);
    ENGINE_READY    = 1'b1;
    ENGINE_DATA_OUT = 64'd14;
    tick();
    ENGINE_READY    = 1'b0;
    tick();
    check_eq("nowd_done_late", DONE_OUT, 4'b0100);
    check_eq("nowd_result", RESULT_OUT, 14);
    check_eq("nowd_err_late", ERROR_OUT, 0);
`endif
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/accelerator_convolution_arbiter.md
ACCELERATOR_CONVOLUTION_ARBITER -- requirements
Module: accelerator_convolution_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 64, meaning the operand and result word width.
REQ-002 The block SHALL have parameter REQUESTERS, fixed at 4, meaning the number of gate controllers sharing one matrix convolution engine.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the watchdog limit in CLK cycles.
REQ-004 The block SHALL have port CLK  input  1  clock.
REQ-005 The block SHALL have port RST  input  1  reset; asynchronous, active-high.
REQ-006 The block SHALL have port REQ_IN  input  4  per-requester request level, held until its DONE_OUT bit.
REQ-007 The block SHALL have port DATA_A_IN  input  4*DATA_SIZE  packed operand A; requester n occupies bits [n*DATA_SIZE +: DATA_SIZE].
REQ-008 The block SHALL have port DATA_B_IN  input  4*DATA_SIZE  packed operand B, with the same packing as DATA_A_IN.
REQ-009 The block SHALL have port GNT_OUT  output  4  one-hot grant, or all zero.
REQ-010 The block SHALL have port DONE_OUT  output  4  one-cycle completion pulse to the granted requester.
REQ-011 The block SHALL have port RESULT_OUT  output  DATA_SIZE  last engine result, valid while any DONE_OUT bit is high.
REQ-012 The block SHALL have port BUSY_OUT  output  1  high in every state except IDLE.
REQ-013 The block SHALL have port ERROR_OUT  output  1  one-cycle watchdog abort pulse.
REQ-014 The block SHALL have port ENGINE_START  output  1  start strobe to the engine.
REQ-015 The block SHALL have port ENGINE_READY  input  1  engine completion strobe.
REQ-016 The block SHALL have ports ENGINE_DATA_A and ENGINE_DATA_B  output  DATA_SIZE each  latched operands for the engine.
REQ-017 The block SHALL have port ENGINE_DATA_OUT  input  DATA_SIZE  engine result.

Function
REQ-018 The FSM SHALL have the states IDLE, START, WAIT and DONE, and SHALL enter IDLE from reset.
REQ-019 In IDLE, if REQ_IN is nonzero, the block SHALL pick the first asserted bit at or after pointer PTR, searching upward modulo 4; PTR resets to 0.
REQ-020 On the IDLE->START edge, the block SHALL register GNT_OUT[g]=1 and latch requester g's operand slices into ENGINE_DATA_A and ENGINE_DATA_B.
REQ-021 In START, ENGINE_START SHALL be 1 for exactly one cycle, then the FSM SHALL move to WAIT.
REQ-022 In WAIT, when ENGINE_READY=1, the block SHALL register ENGINE_DATA_OUT into RESULT_OUT and move to DONE.
REQ-023 ENGINE_READY asserted in any state other than WAIT SHALL be ignored.
REQ-024 In DONE, DONE_OUT[g]=1 for one cycle, GNT_OUT clears, PTR becomes (g+1) mod 4, and the FSM returns to IDLE.
REQ-025 Minimum turnaround from request to DONE SHALL be 4 cycles with ENGINE_READY returned in the first WAIT cycle; one new grant SHALL be possible every 4 cycles.
REQ-026 Simultaneous requests SHALL be served in round-robin order, so no requester waits more than 3 other transactions.
REQ-027 If REQ_IN[g] deasserts after grant, the transaction SHALL still complete and DONE_OUT[g] SHALL still pulse.
REQ-028 REQ_IN bits asserted during START, WAIT or DONE SHALL be evaluated only in the next IDLE cycle.
REQ-029 RESULT_OUT SHALL hold its value until the next capture.

Reset
REQ-030 RST=1 SHALL immediately force state IDLE and PTR=0, and all outputs to 0, RESULT_OUT included.
REQ-031 RST asserted mid-transaction SHALL abort the transaction without a DONE_OUT pulse; the engine SHALL be reset by the same RST.

Configuration
REQ-032 With ACCELERATOR_CONVOLUTION_ARBITER_WATCHDOG_EN defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-033 With the macro defined, when the count reaches TIMEOUT_CYCLES, the block SHALL pulse ERROR_OUT and DONE_OUT[g], leave RESULT_OUT unchanged, advance PTR and return to IDLE.
REQ-034 Without the macro, WAIT SHALL persist indefinitely, ERROR_OUT SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-035 Scenario: single request REQ_IN=0001, A=3, B=5, engine returns 15 one cycle after START -> GNT_OUT=0001 at edge 1, ENGINE_START pulse at edge 1, DONE_OUT=0001 with RESULT_OUT=15 at edge 4.
REQ-036 Scenario: REQ_IN=1111 held -> grant order 0,1,2,3,0 with each DONE_OUT one-hot and exactly one cycle long.
REQ-037 Scenario: PTR=2 after serving requester 1, with REQ_IN=0011 -> requester 0 is granted next (wrap-around), not requester 1.
REQ-038 Scenario: RST pulsed in WAIT -> outputs 0 in the same cycle, no DONE_OUT, and the next request is granted from PTR=0.
REQ-039 Scenario: watchdog macro defined, TIMEOUT_CYCLES=8, ENGINE_READY never asserted -> ERROR_OUT and DONE_OUT[g] pulse 8 cycles after WAIT entry, and RESULT_OUT is unchanged.
REQ-040 Scenario: ENGINE_READY pulsed while in IDLE -> no state change and RESULT_OUT unchanged.
